fl_lfsr_frame_gen: RTL
======================

Name: fl_lfsr_frame_gen

Overview:
- Synthesisable, parametrised FrameLink frame source. Emits pseudo-random frames with pseudo-random lengths in [LEN_MIN, LEN_MAX] from a seeded Galois LFSR.
- Channels are assigned round-robin across CHANNELS channels.
- Sits in front of FrameLink DUTs (e.g. the netcope adder) for hardware-in-loop stimulus, replacing software-side generation. Successor to the fixed-width behavioural LFSR, adding width, channel and length-range parametrisation.

Parameters:
DATA_WIDTH, 64, FrameLink data width in bits; multiple of 8, 8..512
CHANNELS, 4, number of channels, 1..16
LFSR_WIDTH, 32, LFSR width; one of 16/32/64, taps from package
LEN_WIDTH, 16, width of length and config ports

Ports:
CLK  in  1  clock
RESET_N  in  1  synchronous active-low reset
START  in  1  one-cycle pulse, begins a run (ignored while BUSY)
STOP  in  1  one-cycle pulse, ends the run after the current frame
SEED  in  LFSR_WIDTH  loaded on START; 0 is replaced by 1
FRAME_COUNT  in  32  frames per run; 0 = unbounded
LEN_MIN  in  LEN_WIDTH  minimum frame length in bytes
LEN_MAX  in  LEN_WIDTH  maximum frame length in bytes
TX_DATA  out  DATA_WIDTH  frame data
TX_REM  out  log2(DATA_WIDTH/8)  index of last valid byte in word
TX_SOF_N, TX_SOP_N  out  1  start of frame/part (identical, single-part frames)
TX_EOF_N, TX_EOP_N  out  1  end of frame/part (identical)
TX_SRC_RDY_N  out  1  word valid
TX_DST_RDY_N  in  1  sink ready
TX_CHANNEL  out  log2(CHANNELS) (min 1)  channel of the current frame
BUSY  out  1  run active
SENT_CNT  out  32  frames completed in the current run

Behaviour:
- Reset (RESET_N=0 at a rising edge): FSM=IDLE; SRC_RDY_N/SOF_N/SOP_N/EOF_N/EOP_N=1; TX_DATA=0; TX_REM=0; TX_CHANNEL=0; BUSY=0; SENT_CNT=0; LFSR=1.
- Reset mid-frame aborts the frame; no EOF is emitted.
- Transfer occurs when SRC_RDY_N=0 and DST_RDY_N=0. While SRC_RDY_N=0 and DST_RDY_N=1, all TX_* outputs stay stable.
- LFSR: Galois, right-shifting, polynomial from the package. Advances once per LEN computation and once per transferred word.
- Effective bounds: lo = max(LEN_MIN,1); hi = max(LEN_MAX,lo).
- Length: r = hi-lo; m = all-ones mask of bit-length(r); t = lfsr[LEN_WIDTH-1:0] & m.
  - If t > r, then t = t-(r+1).
  - len = lo+t. Config inputs are sampled in LEN state.
- Words per frame: ceil(len/BYTES), where BYTES = DATA_WIDTH/8. TX_REM on the last word = (len-1) mod BYTES; on other words TX_REM = BYTES-1.
- TX_DATA = current LFSR state, replicated/truncated to DATA_WIDTH.
- FSM:
  - IDLE: on START, load SEED, clear SENT_CNT, set BUSY=1 → LEN.
  - LEN (1 cycle): compute len, load word counter, advance LFSR → DATA.
  - DATA: SRC_RDY_N=0. SOF_N/SOP_N=0 on the first word; EOF_N/EOP_N=0 on the last word. A one-word frame asserts all four together.
  - On last-word transfer: SENT_CNT += 1; TX_CHANNEL = (TX_CHANNEL+1) mod CHANNELS.
    - If stop is pending, or SENT_CNT+1 == FRAME_COUNT (FRAME_COUNT≠0): go to IDLE, BUSY=0 the next cycle.
    - Otherwise go to LEN.
- One idle cycle (LEN) separates frames.
- STOP sets a pending flag, cleared on entry to IDLE. STOP in IDLE is ignored. START and STOP in the same cycle from IDLE: start wins; the stop is dropped.
- START while BUSY is ignored.
- SENT_CNT wraps at 2^32. TX_CHANNEL wraps to 0.

Decomposition:
- Package fl_lfsr_gen_pkg: LFSR tap constants per width (16: 0xB400, 32: 0x80200003, 64: 0xD800000000000000), FSM state enum, clog2-min-1 function.
- Sub-module lfsr_galois (WIDTH, TAPS; ports load, seed, step, state).
- Length reduction and the FSM live in the top level.

Test Plan:
- DATA_WIDTH=64, SEED=1, LEN_MIN=LEN_MAX=8, FRAME_COUNT=3, DST_RDY_N=0 → 3 one-word frames with SOF/EOF together, REM=7, channels 0,1,2, SENT_CNT=3, BUSY falls.
- LEN_MIN=LEN_MAX=17, DATA_WIDTH=64 → 3 words per frame; REM=7,7,0; SOF on word 1 only, EOF on word 3 only.
- LEN_MIN=1, LEN_MAX=100, FRAME_COUNT=1000, SEED=0xACE1 → every length in [1,100]; bench reference model matches data and lengths bit-exactly; all 4 channels used 250 times each.
- Random DST_RDY_N (50%) → outputs stable during stalls; word count and data identical to the no-stall run with the same seed.
- FRAME_COUNT=0, STOP pulsed mid-frame 5 → frame 5 completes with EOF, SENT_CNT=5, BUSY=0; START+STOP in the same cycle from IDLE → run starts.
- RESET_N low mid-frame → next cycle SRC_RDY_N=1, BUSY=0, SENT_CNT=0; LEN_MIN=50, LEN_MAX=10 → all frames 50 bytes; SEED=0 → behaves as SEED=1.

Source files
------------

// File: rtl/fl_lfsr_gen_pkg.sv
// Shared definitions for the FrameLink LFSR frame generator: LFSR taps,
// FSM state encoding and width helpers.
package fl_lfsr_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LEN,
        ST_DATA
    } state_t;

    localparam logic [63:0] TAPS16 = 64'h0000_0000_0000_B400;
    localparam logic [63:0] TAPS32 = 64'h0000_0000_8020_0003;
    localparam logic [63:0] TAPS64 = 64'hD800_0000_0000_0000;

    function automatic logic [63:0] lfsr_taps(input int unsigned width);
        case (width)
            16:      return TAPS16;
            64:      return TAPS64;
            default: return TAPS32;
        endcase
    endfunction

    // Index width for n items, never narrower than one bit.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/lfsr_galois.sv
// Right-shifting Galois LFSR with seed load; an all-zero seed is replaced
// by 1 so the register never locks up.
module lfsr_galois
    import fl_lfsr_gen_pkg::*;
#(
    parameter int unsigned       WIDTH = 32,
    parameter logic [WIDTH-1:0]  TAPS  = WIDTH'(lfsr_taps(WIDTH))
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] seed,
    input  logic             step,
    output logic [WIDTH-1:0] state
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= WIDTH'(1);
        end else if (load) begin
            state <= (seed == '0) ? WIDTH'(1) : seed;
        end else if (step) begin
            state <= state[0] ? ((state >> 1) ^ TAPS) : (state >> 1);
        end
    end

endmodule

// File: rtl/fl_lfsr_frame_gen.sv
// FrameLink pseudo-random frame source: LFSR-derived lengths and data,
// round-robin channel assignment, bounded or unbounded runs.
module fl_lfsr_frame_gen
    import fl_lfsr_gen_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned CHANNELS   = 4,
    parameter int unsigned LFSR_WIDTH = 32,
    parameter int unsigned LEN_WIDTH  = 16
) (
    input  logic                                     CLK,
    input  logic                                     RESET_N,
    input  logic                                     START,
    input  logic                                     STOP,
    input  logic [LFSR_WIDTH-1:0]                    SEED,
    input  logic [31:0]                              FRAME_COUNT,
    input  logic [LEN_WIDTH-1:0]                     LEN_MIN,
    input  logic [LEN_WIDTH-1:0]                     LEN_MAX,
    output logic [DATA_WIDTH-1:0]                    TX_DATA,
    output logic [clog2_min1(DATA_WIDTH/8)-1:0]      TX_REM,
    output logic                                     TX_SOF_N,
    output logic                                     TX_SOP_N,
    output logic                                     TX_EOF_N,
    output logic                                     TX_EOP_N,
    output logic                                     TX_SRC_RDY_N,
    input  logic                                     TX_DST_RDY_N,
    output logic [clog2_min1(CHANNELS)-1:0]          TX_CHANNEL,
    output logic                                     BUSY,
    output logic [31:0]                              SENT_CNT
);

    localparam int unsigned BYTES = DATA_WIDTH / 8;
    localparam int unsigned REM_W = clog2_min1(BYTES);
    localparam int unsigned CH_W  = clog2_min1(CHANNELS);

    state_t                 state, state_next;
    logic [LFSR_WIDTH-1:0]  lfsr;
    logic [LEN_WIDTH-1:0]   bytes_left;
    logic [LEN_WIDTH-1:0]   lo, hi, r, m, t, len;
    logic                   first, stop_pend, xfer, last, run_done;
    logic [31:0]            sent_cnt;
    logic [CH_W-1:0]        channel;

    lfsr_galois #(
        .WIDTH (LFSR_WIDTH),
        .TAPS  (LFSR_WIDTH'(lfsr_taps(LFSR_WIDTH)))
    ) u_lfsr (
        .clk   (CLK),
        .rst_n (RESET_N),
        .load  (state == ST_IDLE && START),
        .seed  (SEED),
        .step  (state == ST_LEN || xfer),
        .state (lfsr)
    );

    // Fold the masked LFSR sample back into [0, r] with one conditional subtract.
    always_comb begin
        lo = (LEN_MIN == '0) ? LEN_WIDTH'(1) : LEN_MIN;
        hi = (LEN_MAX > lo) ? LEN_MAX : lo;
        r  = hi - lo;
        m  = '0;
        for (int unsigned i = 0; i < LEN_WIDTH; i++) begin
            m[i] = |(r >> i);
        end
        t = LEN_WIDTH'(lfsr) & m;
        if (t > r) begin
            t = t - (r + LEN_WIDTH'(1));
        end
        len = lo + t;
    end

    always_comb begin
        state_next   = state;
        last         = (bytes_left <= LEN_WIDTH'(BYTES));
        xfer         = (state == ST_DATA) && !TX_DST_RDY_N;
        run_done     = stop_pend || STOP ||
                       (FRAME_COUNT != '0 && (sent_cnt + 32'd1) == FRAME_COUNT);
        TX_SRC_RDY_N = 1'b1;
        TX_SOF_N     = 1'b1;
        TX_EOF_N     = 1'b1;
        TX_REM       = '0;
        TX_DATA      = '0;
        case (state)
            ST_IDLE: if (START) state_next = ST_LEN;
            ST_LEN:  state_next = ST_DATA;
            ST_DATA: begin
                TX_SRC_RDY_N = 1'b0;
                TX_SOF_N     = !first;
                TX_EOF_N     = !last;
                TX_REM       = last ? REM_W'(bytes_left - LEN_WIDTH'(1)) : REM_W'(BYTES - 1);
                for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
                    TX_DATA[i] = lfsr[i % LFSR_WIDTH];
                end
                if (xfer && last) begin
                    state_next = run_done ? ST_IDLE : ST_LEN;
                end
            end
            default: state_next = ST_IDLE;
        endcase
        TX_SOP_N = TX_SOF_N;
        TX_EOP_N = TX_EOF_N;
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state      <= ST_IDLE;
            bytes_left <= '0;
            first      <= 1'b0;
            stop_pend  <= 1'b0;
            sent_cnt   <= '0;
            channel    <= '0;
        end else begin
            state <= state_next;
            // A STOP arriving together with START from IDLE is dropped.
            if (state == ST_IDLE || state_next == ST_IDLE) begin
                stop_pend <= 1'b0;
            end else if (STOP) begin
                stop_pend <= 1'b1;
            end
            if (state == ST_IDLE && START) begin
                sent_cnt <= '0;
            end
            if (state == ST_LEN) begin
                bytes_left <= len;
                first      <= 1'b1;
            end
            if (xfer) begin
                first <= 1'b0;
                if (last) begin
                    sent_cnt <= sent_cnt + 32'd1;
                    channel  <= (channel == CH_W'(CHANNELS - 1)) ? '0 : channel + CH_W'(1);
                end else begin
                    bytes_left <= bytes_left - LEN_WIDTH'(BYTES);
                end
            end
        end
    end

    assign BUSY       = (state != ST_IDLE);
    assign SENT_CNT   = sent_cnt;
    assign TX_CHANNEL = channel;

endmodule
